icache_assoc: RTL and testbench

ICACHE_ASSOC -- requirements
Module: icache_assoc

---
 rtl/icache_assoc.sv | 151 +++++++++++++++
 tb/tb_icache_assoc.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/icache_assoc.sv
// Instruction cache with 1- or 2-way set associativity, one word per line,
// blocking miss handling through a two-state IDLE/MISS controller.
module icache_assoc #(
    parameter int SETS = 16,
    parameter int WAYS = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        invalidate,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {
        IDLE,
        MISS
    } state_t;

    state_t             state_q, state_d;
    logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;
    logic [IDX_W-1:0]   miss_idx_q, miss_idx_d;
    logic [SETS-1:0]    valid_q [WAYS];
    logic [SETS-1:0]    valid_d [WAYS];
    logic [SETS-1:0]    lru_q, lru_d;
    logic [TAG_W-1:0]   tag_q   [WAYS][SETS];
    logic [31:0]        data_q  [WAYS][SETS];

    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic               hit_any;
    logic               hit_way;
    logic [31:0]        hit_data;
    logic               fill_way;
    logic               fill_en;
    logic               unused_offset;

    assign req_idx       = imemaddr[IDX_W+1:2];
    assign req_tag       = imemaddr[31:IDX_W+2];
    assign unused_offset = ^imemaddr[1:0];

    always_comb begin
        hit_any  = 1'b0;
        hit_way  = 1'b0;
        hit_data = 32'h0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
                hit_any  = 1'b1;
                hit_way  = 1'(w);
                hit_data = data_q[w][req_idx];
            end
        end
    end

    // Descending scan so the lowest-numbered invalid way wins over the LRU choice.
    always_comb begin
        fill_way = (WAYS == 2) ? lru_q[miss_idx_q] : 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w][miss_idx_q]) begin
                fill_way = 1'(w);
            end
        end
    end

    assign ihit     = (state_q == IDLE) && imemREN && hit_any;
    assign imemload = ihit ? hit_data : 32'h0;
    assign iREN     = (state_q == MISS);
    assign iaddr    = iREN ? {miss_tag_q, miss_idx_q, 2'b00} : 32'h0;
    assign fill_en  = (state_q == MISS) && !iwait && !invalidate;

    always_comb begin
        state_d    = state_q;
        miss_tag_d = miss_tag_q;
        miss_idx_d = miss_idx_q;
        valid_d    = valid_q;
        lru_d      = lru_q;
        if (invalidate) begin
            state_d = IDLE;
            lru_d   = '0;
            for (int w = 0; w < WAYS; w++) begin
                valid_d[w] = '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (imemREN) begin
                        if (hit_any) begin
                            if (WAYS == 2) begin
                                lru_d[req_idx] = ~hit_way;
                            end
                        end else begin
                            miss_tag_d = req_tag;
                            miss_idx_d = req_idx;
                            state_d    = MISS;
                        end
                    end
                end
                MISS: begin
                    if (!iwait) begin
                        for (int w = 0; w < WAYS; w++) begin
                            if (1'(w) == fill_way) begin
                                valid_d[w][miss_idx_q] = 1'b1;
                            end
                        end
                        if (WAYS == 2) begin
                            lru_d[miss_idx_q] = ~fill_way;
                        end
                        state_d = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
            lru_q      <= '0;
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
            end
        end else begin
            state_q    <= state_d;
            miss_tag_q <= miss_tag_d;
            miss_idx_q <= miss_idx_d;
            lru_q      <= lru_d;
            valid_q    <= valid_d;
        end
    end

    // Tag and data storage carry no reset; the valid bits alone qualify them.
    always_ff @(posedge CLK) begin
        for (int w = 0; w < WAYS; w++) begin
            if (fill_en && (1'(w) == fill_way)) begin
                tag_q[w][miss_idx_q]  <= miss_tag_q;
                data_q[w][miss_idx_q] <= iload;
            end
        end
    end

endmodule

// File: tb/tb_icache_assoc.sv
// Scoreboard bench for icache_assoc: a 2-way instance and a direct-mapped
// instance, each driven by a bench-side memory responder.
module tb_icache_assoc;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          latency;
    } expT;

    logic        CLK;
    logic        nRST;
    logic        ren    [2];
    logic [31:0] addr   [2];
    logic        inval  [2];
    logic        iwaitS [2];
    logic [31:0] iloadS [2];
    logic        hitO   [2];
    logic [31:0] loadO  [2];
    logic        irenO  [2];
    logic [31:0] iaddrO [2];

    expT sbQ[$];
    int  errors = 0;
    int  checks = 0;

    icache_assoc #(.SETS(16), .WAYS(2)) u_dut2 (
        .CLK(CLK), .nRST(nRST),
        .imemREN(ren[0]), .imemaddr(addr[0]), .invalidate(inval[0]),
        .ihit(hitO[0]), .imemload(loadO[0]),
        .iREN(irenO[0]), .iaddr(iaddrO[0]),
        .iwait(iwaitS[0]), .iload(iloadS[0])
    );

    icache_assoc #(.SETS(16), .WAYS(1)) u_dut1 (
        .CLK(CLK), .nRST(nRST),
        .imemREN(ren[1]), .imemaddr(addr[1]), .invalidate(inval[1]),
        .ihit(hitO[1]), .imemload(loadO[1]),
        .iREN(irenO[1]), .iaddr(iaddrO[1]),
        .iwait(iwaitS[1]), .iload(iloadS[1])
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got running want finished");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] memWord(input logic [31:0] a);
        logic [31:0] al;
        al = {a[31:2], 2'b00};
        if (al == 32'h0000_0040) return 32'hDEAD_BEEF;
        return {al[15:0] ^ 16'h5A5A, 16'hC0DE};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h want %h", tag, actual, expected);
        end
    endtask

    // One read from entry just after a negedge; returns just after a later negedge.
    task automatic applyStimulus(input int sel, input logic [31:0] a, input bit expHit,
                                 input int waitCycles, input logic [31:0] switchAddr);
        expT e;
        int  renSeen;
        bit  done;
        e.addr    = a;
        e.data    = memWord(a);
        e.latency = expHit ? 0 : waitCycles + 2;
        sbQ.push_back(e);
        ren[sel]    = 1'b1;
        addr[sel]   = a;
        iwaitS[sel] = 1'b1;
        iloadS[sel] = 32'h0;
        renSeen = 0;
        done    = 1'b0;
        for (int cyc = 0; cyc < waitCycles + 10 && !done; cyc++) begin
            #1;
            if (hitO[sel]) begin
                e = sbQ.pop_front();
                checkOutput("hitData", loadO[sel], e.data);
                checkOutput("hitLatency", 32'(cyc), 32'(e.latency));
                checkOutput("irenOnHit", {31'b0, irenO[sel]}, 32'd0);
                done = 1'b1;
            end else begin
                if (cyc == 0) begin
                    checkOutput("missLoad", loadO[sel], 32'd0);
                    checkOutput("missIdleIren", {31'b0, irenO[sel]}, 32'd0);
                    checkOutput("missIdleIaddr", iaddrO[sel], 32'd0);
                end
                if (irenO[sel]) begin
                    checkOutput("iaddr", iaddrO[sel], {a[31:2], 2'b00});
                    iwaitS[sel] = (renSeen < waitCycles);
                    iloadS[sel] = (renSeen < waitCycles) ? 32'h0 : memWord(a);
                    if (switchAddr != 32'h0) begin
                        addr[sel] = (renSeen < waitCycles) ? switchAddr : a;
                    end
                    renSeen++;
                end
            end
            @(negedge CLK);
        end
        if (!done) begin
            checkOutput("hitTimeout", 32'd0, 32'd1);
            void'(sbQ.pop_front());
        end
        checkOutput("irenCycles", 32'(renSeen), expHit ? 32'd0 : 32'(waitCycles + 1));
        ren[sel]    = 1'b0;
        addr[sel]   = 32'h0;
        iwaitS[sel] = 1'b1;
        iloadS[sel] = 32'h0;
    endtask

    task automatic invalidateDuringMiss(input int sel, input logic [31:0] a, input bit fillSame);
        ren[sel]  = 1'b1;
        addr[sel] = a;
        #1;
        checkOutput("invStartHit", {31'b0, hitO[sel]}, 32'd0);
        @(negedge CLK);
        #1;
        checkOutput("invMissIren", {31'b0, irenO[sel]}, 32'd1);
        inval[sel] = 1'b1;
        if (fillSame) begin
            iwaitS[sel] = 1'b0;
            iloadS[sel] = memWord(a);
        end
        @(negedge CLK);
        inval[sel]  = 1'b0;
        ren[sel]    = 1'b0;
        addr[sel]   = 32'h0;
        iwaitS[sel] = 1'b1;
        iloadS[sel] = 32'h0;
        #1;
        checkOutput("invIrenAfter", {31'b0, irenO[sel]}, 32'd0);
        checkOutput("invIaddrAfter", iaddrO[sel], 32'd0);
        @(negedge CLK);
    endtask

    initial begin
        logic [31:0] alt [4];
        nRST = 1'b0;
        for (int s = 0; s < 2; s++) begin
            ren[s]    = 1'b0;
            addr[s]   = 32'h0;
            inval[s]  = 1'b0;
            iwaitS[s] = 1'b1;
            iloadS[s] = 32'h0;
        end
        repeat (2) @(negedge CLK);
        #1;
        for (int s = 0; s < 2; s++) begin
            checkOutput("rstHit", {31'b0, hitO[s]}, 32'd0);
            checkOutput("rstLoad", loadO[s], 32'd0);
            checkOutput("rstIren", {31'b0, irenO[s]}, 32'd0);
            checkOutput("rstIaddr", iaddrO[s], 32'd0);
        end
        @(negedge CLK);
        nRST = 1'b1;

        $display("[TB] cold miss, hits, 2-way conflict");
        applyStimulus(0, 32'h0000_0040, 1'b0, 3, 32'h0);
        applyStimulus(0, 32'h0000_0040, 1'b1, 0, 32'h0);
        applyStimulus(0, 32'h0000_0043, 1'b1, 0, 32'h0);
        applyStimulus(0, 32'h0000_0080, 1'b0, 1, 32'h0);
        applyStimulus(0, 32'h0000_0040, 1'b1, 0, 32'h0);
        applyStimulus(0, 32'h0000_00C0, 1'b0, 0, 32'h0);
        applyStimulus(0, 32'h0000_0040, 1'b1, 0, 32'h0);
        applyStimulus(0, 32'h0000_00C0, 1'b1, 0, 32'h0);
        applyStimulus(0, 32'h0000_0080, 1'b0, 2, 32'h0);

        $display("[TB] address change during miss");
        applyStimulus(0, 32'h0000_0100, 1'b0, 3, 32'h0000_0200);
        applyStimulus(0, 32'h0000_0100, 1'b1, 0, 32'h0);
        applyStimulus(0, 32'h0000_0200, 1'b0, 1, 32'h0);

        $display("[TB] invalidate during miss");
        invalidateDuringMiss(0, 32'h0000_0044, 1'b0);
        applyStimulus(0, 32'h0000_0044, 1'b0, 1, 32'h0);
        applyStimulus(0, 32'h0000_0100, 1'b0, 0, 32'h0);
        invalidateDuringMiss(0, 32'h0000_0048, 1'b1);
        applyStimulus(0, 32'h0000_0048, 1'b0, 0, 32'h0);

        $display("[TB] direct-mapped alternation");
        alt[0] = 32'h0000_0040;
        alt[1] = 32'h0000_0080;
        alt[2] = 32'h0000_0040;
        alt[3] = 32'h0000_0080;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, alt[i], 1'b0, 1, 32'h0);
        end

        $display("[TB] reset during miss");
        ren[0]  = 1'b1;
        addr[0] = 32'h0000_0400;
        @(negedge CLK);
        #1;
        checkOutput("rstMissIren", {31'b0, irenO[0]}, 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        checkOutput("rstAsyncIren", {31'b0, irenO[0]}, 32'd0);
        checkOutput("rstAsyncIaddr", iaddrO[0], 32'd0);
        @(negedge CLK);
        nRST   = 1'b1;
        ren[0] = 1'b0;
        applyStimulus(0, 32'h0000_0400, 1'b0, 1, 32'h0);

        checkOutput("sbLeftover", 32'(sbQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
